// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg
// Shared constants and state encoding for the SPI byte engine.
// Revision: 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_BITS   = 8;
  localparam int SPI_HALVES = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_half_tick
// Counts CLK_DIV system clocks and emits a one-cycle tick in the last cycle
// of every sck half-period. A synchronous clear holds the count at zero.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // The tick marks the final cycle of a half-period; it is masked while cleared.
  assign tick_o = (cnt_q == LAST) && !clr_i;

  // Divider count: reloads to 0 on clear and at every half-period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule : spi_half_tick
`default_nettype wire

// File: rtl/spi_byte_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_byte_engine
// Mode-0, MSB-first SPI master byte shifter. Accepts a byte and a start
// strobe, drives ss/sck/mosi from registers, captures miso on sck rises and
// returns the received byte with a done pulse and a sticky new_data flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                rx_ack,
  input  logic                miso,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                busy,
  output logic                done,
  output logic                new_data,
  output logic                mosi,
  output logic                sck,
  output logic                ss
);

  localparam logic [3:0] LAST_HALF = 4'(SPI_HALVES - 1);

  spi_state_e          state_q, state_d;
  logic [3:0]          half_q, half_d;
  // Only the bits not yet on mosi are kept; bit 7 goes straight to mosi.
  logic [SPI_BITS-2:0] tx_sr_q, tx_sr_d;
  logic [SPI_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic                sck_q, sck_d;
  logic                ss_q, ss_d;
  logic                mosi_q, mosi_d;
  logic                new_data_q, new_data_d;
  logic                tick;
  logic                div_clr;

  // The divider only runs while a transfer is in progress.
  assign div_clr = (state_q == IDLE) || (state_q == DONE);

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  // State and datapath registers; reset returns every output to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      half_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      new_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      new_data_q <= new_data_d;
    end
  end

  // Next-state logic: sequencing, bit shifting and the sticky flag.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    new_data_d = new_data_q;

    // Acknowledge clears the flag; a DONE entry below overrides it.
    if (rx_ack) begin
      new_data_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d = tx_data[SPI_BITS-2:0];
          mosi_d  = tx_data[SPI_BITS-1];
          ss_d    = 1'b0;
          half_d  = '0;
          rx_sr_d = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!half_q[0]) begin
            // End of a low half: sck rises, sample the slave.
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[SPI_BITS-2:0], miso};
            half_d  = half_q + 4'd1;
          end else begin
            // End of a high half: sck falls, present the next bit.
            sck_d = 1'b0;
            if (half_q == LAST_HALF) begin
              mosi_d  = 1'b0;
              half_d  = '0;
              state_d = HOLD;
            end else begin
              mosi_d  = tx_sr_q[SPI_BITS-2];
              tx_sr_d = {tx_sr_q[SPI_BITS-3:0], 1'b0};
              half_d  = half_q + 4'd1;
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          ss_d       = 1'b1;
          rx_data_d  = rx_sr_q;
          new_data_d = 1'b1;
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign done     = (state_q == DONE);
  assign rx_data  = rx_data_q;
  assign new_data = new_data_q;
  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign ss       = ss_q;

endmodule : spi_byte_engine
`default_nettype wire

// File: tb/tb_spi_byte_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_byte_engine
// Self-checking bench for the SPI byte engine with a received-byte scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spi_byte_engine;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 18 * CLK_DIV;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic       rx_ack  = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso;
  logic [7:0] rx_data;
  logic       busy, done, new_data, mosi, sck, ss;

  int miso_mode = 0;  // 0: loopback, 1: tied high, 2: tied low
  int tests     = 0;
  int fails     = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    miso = mosi;
    if (miso_mode == 1) miso = 1'b1;
    else if (miso_mode == 2) miso = 1'b0;
  end

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .rx_ack   (rx_ack),
    .miso     (miso),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .new_data (new_data),
    .mosi     (mosi),
    .sck      (sck),
    .ss       (ss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer from its accepting edge E0 to E0+LAT+20, optionally
  // pulsing start or rx_ack at given edges; done results go via the scoreboard.
  task automatic run_xfer(input logic [7:0] tx, input int mode,
                          input int ign1, input int ign2,
                          input int ack1, input int ack2,
                          output int done_at, output int done_cnt,
                          output int pulses, output logic [7:0] bits,
                          output int ss_bad, output logic nd_done,
                          output logic nd_after, output logic [7:0] rx_after);
    logic       prev_sck;
    logic [7:0] exp;
    int         d_at, d_cnt, pl, sb;
    logic [7:0] bt, ra;
    logic       ndd, nda;
    d_at = -1; d_cnt = 0; pl = 0; sb = 0; bt = 8'h00; ra = 8'h00;
    ndd = 1'b0; nda = 1'b0;
    miso_mode = mode;
    exp = (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : tx;
    exp_q.push_back(exp);
    tx_data = tx;
    start   = 1'b1;
    tick();                 // edge E0
    start    = 1'b0;
    tx_data  = ~tx;         // must not affect the running transfer
    prev_sck = sck;
    for (int n = 0; n <= LAT + 20; n++) begin
      if (n > 0) begin
        start = (n == ign1) || (n == ign2);
        if (start) tx_data = 8'h00;
        rx_ack = (n == ack1) || (n == ack2);
        tick();
        start  = 1'b0;
        rx_ack = 1'b0;
      end
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        pl++;
        bt = {bt[6:0], mosi};
      end
      prev_sck = sck;
      if (n < LAT && (ss !== 1'b0 || busy !== 1'b1)) sb++;
      if (n >= LAT && (ss !== 1'b1 || busy !== 1'b0)) sb++;
      if (done === 1'b1) begin
        d_cnt++;
        if (d_at < 0) d_at = n;
        ndd = new_data;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: unexpected done, rx_data=%h", rx_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data !== exp) begin
            fails++;
            $display("FAIL scoreboard rx_data: got %h expected %h", rx_data, exp);
          end
        end
      end
      if (n == LAT + 1) begin
        nda = new_data;
        ra  = rx_data;
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d expected bytes never produced", exp_q.size());
      exp_q.delete();
    end
    done_at = d_at; done_cnt = d_cnt; pulses = pl; bits = bt; ss_bad = sb;
    nd_done = ndd; nd_after = nda; rx_after = ra;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;          // mid-cycle, no clock edge before the checks
    #1;
    tests++; if (ss !== 1'b1)         begin fails++; $display("FAIL reset ss: got %b expected 1", ss); end
    tests++; if (sck !== 1'b0)        begin fails++; $display("FAIL reset sck: got %b expected 0", sck); end
    tests++; if (mosi !== 1'b0)       begin fails++; $display("FAIL reset mosi: got %b expected 0", mosi); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0)       begin fails++; $display("FAIL reset done: got %b expected 0", done); end
    tests++; if (new_data !== 1'b0)   begin fails++; $display("FAIL reset new_data: got %b expected 0", new_data); end
    tests++; if (rx_data !== 8'h00)   begin fails++; $display("FAIL reset rx_data: got %h expected 00", rx_data); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_xfer(input string name, input logic [7:0] tx, input int mode,
                           input int ign1, input int ign2);
    int d_at, d_cnt, pl, sb;
    logic [7:0] bt, ra;
    logic ndd, nda;
    run_xfer(tx, mode, ign1, ign2, -1, -1, d_at, d_cnt, pl, bt, sb, ndd, nda, ra);
    tests++; if (d_at != LAT) begin fails++; $display("FAIL %s done_at: got %0d expected %0d", name, d_at, LAT); end
    tests++; if (d_cnt != 1)  begin fails++; $display("FAIL %s done_count: got %0d expected 1", name, d_cnt); end
    tests++; if (pl != 8)     begin fails++; $display("FAIL %s sck_pulses: got %0d expected 8", name, pl); end
    tests++; if (bt !== tx)   begin fails++; $display("FAIL %s mosi_bits: got %h expected %h", name, bt, tx); end
    tests++; if (sb != 0)     begin fails++; $display("FAIL %s ss_busy_window: got %0d bad cycles expected 0", name, sb); end
    tests++; if (ndd !== 1'b1) begin fails++; $display("FAIL %s new_data: got %b expected 1", name, ndd); end
  endtask

  task automatic test_loopback();
    test_xfer("loopback_b9", 8'hB9, 0, -1, -1);
  endtask

  task automatic test_miso_tied();
    test_xfer("miso_high", 8'h3C, 1, -1, -1);
    test_xfer("miso_low", 8'hC3, 2, -1, -1);
  endtask

  task automatic test_ignored_start();
    test_xfer("ignored_start", 8'hB9, 0, 20, LAT + 1);
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    miso_mode = 0;
    tx_data = 8'h77;
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    for (int n = 1; n < 30; n++) tick();
    #3 rst = 1'b1;          // before edge E0+30, asynchronous
    #1;
    tests++; if (ss !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL midreset outputs: ss=%b sck=%b mosi=%b busy=%b done=%b expected 1,0,0,0,0", ss, sck, mosi, busy, done); end
    tests++; if (rx_data !== 8'h00 || new_data !== 1'b0)
      begin fails++; $display("FAIL midreset rx: rx_data=%h new_data=%b expected 00,0", rx_data, new_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < LAT + 10; n++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midreset quiet: got %0d active cycles expected 0", bad); end
    test_xfer("after_reset_5a", 8'h5A, 0, -1, -1);
  endtask

  task automatic test_rx_ack();
    int d_at, d_cnt, pl, sb;
    logic [7:0] bt, ra;
    logic ndd, nda;
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    tests++; if (new_data !== 1'b0) begin fails++; $display("FAIL ack_clear new_data: got %b expected 0", new_data); end
    run_xfer(8'hA5, 0, -1, -1, LAT, LAT + 1, d_at, d_cnt, pl, bt, sb, ndd, nda, ra);
    tests++; if (ndd !== 1'b1) begin fails++; $display("FAIL ack_coincident new_data: got %b expected 1", ndd); end
    tests++; if (nda !== 1'b0) begin fails++; $display("FAIL ack_after new_data: got %b expected 0", nda); end
    tests++; if (ra !== 8'hA5) begin fails++; $display("FAIL ack_after rx_data: got %h expected a5", ra); end
    tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL ack_final rx_data: got %h expected a5", rx_data); end
    tests++; if (d_at != LAT) begin fails++; $display("FAIL ack done_at: got %0d expected %0d", d_at, LAT); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_tied();
    test_ignored_start();
    test_mid_reset();
    test_rx_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_spi_byte_engine
`default_nettype wire
